// File: rtl/stream_packet_fifo_if.sv
// Beat-stream bundle around stream_packet_fifo: upstream (s_*) and downstream (m_*) handshakes.
// The slave modport is the buffer's view; the master modport is the surrounding environment's view.
interface stream_packet_fifo_if #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int T_ID___WIDTH = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_in;
    logic [T_QOS__WIDTH-1:0] s_qos_in;
    logic [T_ID___WIDTH-1:0] s_id_in;
    logic                    s_last_in;
    logic                    s_valid_in;
    logic                    s_ready_out;
    logic [T_DATA_WIDTH-1:0] m_data_out;
    logic [T_QOS__WIDTH-1:0] m_qos_out;
    logic [T_ID___WIDTH-1:0] m_id_out;
    logic                    m_last_out;
    logic                    m_valid_out;
    logic                    m_ready_in;

    modport slave (
        input  s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in, m_ready_in,
        output s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out
    );

    modport master (
        output s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in, m_ready_in,
        input  s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out
    );
endinterface

// File: rtl/stream_packet_fifo.sv
// Store-and-forward packet buffer: a packet is released only once its last beat is stored.
// Define STREAM_PACKET_FIFO_CUT_THROUGH_EN to forward every beat as soon as it is stored.
module stream_packet_fifo #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int T_ID___WIDTH = 2,
    parameter int DEPTH        = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    stream_packet_fifo_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0]   level_out,
    output logic [$clog2(DEPTH+1)-1:0]   pkt_count_out
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int EW  = T_DATA_WIDTH + T_QOS__WIDTH + T_ID___WIDTH + 1;
    localparam logic [AW:0] FULL_LVL = AW1'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          ready_q, ready_d;
    logic [AW:0]   level_s, level_d;
    logic [EW-1:0] head_s;
    logic          wr_en_s, rd_en_s, valid_s;
    logic          wr_last_s, rd_last_s;

    // Pointer MSB separates full from empty, so the difference is the exact level.
    assign level_s = wr_ptr_q - rd_ptr_q;
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

`ifdef STREAM_PACKET_FIFO_CUT_THROUGH_EN
    assign valid_s = (level_s != '0);
`else
    // A full buffer with no complete packet streams out anyway to avoid deadlock.
    assign valid_s = (level_s != '0) && ((pkt_cnt_q != '0) || (level_s == FULL_LVL));
`endif

    assign wr_en_s   = bus.s_valid_in && ready_q;
    assign rd_en_s   = valid_s && bus.m_ready_in;
    assign wr_last_s = wr_en_s && bus.s_last_in;
    assign rd_last_s = rd_en_s && head_s[EW-1];

    // Next-state for pointers, level, packet count and upstream ready.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_s;
        pkt_cnt_d = pkt_cnt_q;
        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW1'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + AW1'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   level_d = level_s + AW1'(1);
            2'b01:   level_d = level_s - AW1'(1);
            default: level_d = level_s;
        endcase
        case ({wr_last_s, rd_last_s})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        // Ready looks at the post-edge level, so a read while full frees the slot one cycle later.
        ready_d = (level_d != FULL_LVL);
    end

    // State registers and beat storage; reset discards everything and clears the entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            ready_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            ready_q   <= ready_d;
            if (wr_en_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {bus.s_last_in, bus.s_id_in, bus.s_qos_in, bus.s_data_in};
            end
        end
    end

    assign bus.s_ready_out = ready_q;
    assign bus.m_valid_out = valid_s;
    assign bus.m_data_out  = head_s[T_DATA_WIDTH-1:0];
    assign bus.m_qos_out   = head_s[T_DATA_WIDTH +: T_QOS__WIDTH];
    assign bus.m_id_out    = head_s[T_DATA_WIDTH+T_QOS__WIDTH +: T_ID___WIDTH];
    assign bus.m_last_out  = head_s[EW-1];
    assign level_out       = CW'(level_s);
    assign pkt_count_out   = pkt_cnt_q;
endmodule
